// File: rtl/nic_sched_pkg.sv
// Shared types for nic_access_scheduler.
// State, last-service encoding and NIC register map.
package nic_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_IN,
    READ_IN,
    POLL_OUT,
    WRITE_OUT
  } state_t;

  typedef enum logic {
    SVC_RX = 1'b0,
    SVC_TX = 1'b1
  } svc_t;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after ptr, wrapping; the parent owns ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      win_idx,
  output logic               any
);

  logic [IW-1:0] idx;

  // scan from farthest to nearest so the nearest wins
  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        win_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nic_access_scheduler.sv
// Sole master of the NIC register port: rx drain + RR tx.
// Optional stats counters: NIC_SCHED_STATS_EN.
module nic_access_scheduler
  import nic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rx_valid,
  output logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_ready,
  output logic [1:0]                nic_addr,
  output logic [DATA_W-1:0]         nic_d_in,
  input  logic [DATA_W-1:0]         nic_d_out,
  output logic                      nic_en,
  output logic                      nic_en_wr
`ifdef NIC_SCHED_STATS_EN
  ,
  output logic [15:0]               tx_count,
  output logic [15:0]               rx_count
`endif
);

  state_t        state;
  svc_t          last_svc;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic          rx_ok;

  logic [DATA_W-1:0] req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  assign rx_ok = !rx_valid;

  // scheduler FSM plus rx slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_svc <= SVC_TX;
      rr_ptr   <= '0;
      win_idx  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_ok && (last_svc == SVC_TX || !arb_any)) begin
            state <= POLL_IN;
          end else if (arb_any) begin
            win_idx <= arb_idx;
            state   <= POLL_OUT;
          end
        end
        POLL_IN: begin
          if (nic_d_out[0]) begin
            state <= READ_IN;
          end else begin
            last_svc <= SVC_RX;
            state    <= IDLE;
          end
        end
        READ_IN: begin
          rx_data  <= nic_d_out;
          rx_valid <= 1'b1;
          last_svc <= SVC_RX;
          state    <= IDLE;
        end
        POLL_OUT: begin
          if (!nic_d_out[0] && req_valid[win_idx]) begin
            state <= WRITE_OUT;
          end else begin
            last_svc <= SVC_TX;
            state    <= IDLE;
          end
        end
        WRITE_OUT: begin
          rr_ptr   <= (win_idx == IW'(NUM_REQ - 1)) ?
                      '0 : win_idx + 1'b1;
          last_svc <= SVC_TX;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NIC pins and ready pulse decoded from state only
  always_comb begin
    nic_en    = 1'b0;
    nic_en_wr = 1'b0;
    nic_addr  = NIC_ADDR_IN_BUF;
    nic_d_in  = '0;
    req_ready = '0;
    unique case (1'b1)
      (state == POLL_IN): begin
        nic_en   = 1'b1;
        nic_addr = NIC_ADDR_IN_STAT;
      end
      (state == READ_IN): begin
        nic_en   = 1'b1;
        nic_addr = NIC_ADDR_IN_BUF;
      end
      (state == POLL_OUT): begin
        nic_en   = 1'b1;
        nic_addr = NIC_ADDR_OUT_STAT;
      end
      (state == WRITE_OUT): begin
        nic_en             = 1'b1;
        nic_en_wr          = 1'b1;
        nic_addr           = NIC_ADDR_OUT_BUF;
        nic_d_in           = req_word[win_idx];
        req_ready[win_idx] = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef NIC_SCHED_STATS_EN
  // wrapping transfer counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (state == WRITE_OUT) tx_count <= tx_count + 16'd1;
      if (state == READ_IN)   rx_count <= rx_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nic_access_scheduler.sv
// Self-checking bench for nic_access_scheduler.
// Behavioural NIC model, RR model and write scoreboard.
module tb_nic_access_scheduler;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rx_valid;
  logic [W-1:0]   rx_data;
  logic           rx_ready;
  logic [1:0]     nic_addr;
  logic [W-1:0]   nic_d_in;
  logic [W-1:0]   nic_d_out;
  logic           nic_en;
  logic           nic_en_wr;
`ifdef NIC_SCHED_STATS_EN
  logic [15:0]    tx_count;
  logic [15:0]    rx_count;
`endif

  nic_access_scheduler #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .nic_addr  (nic_addr),
    .nic_d_in  (nic_d_in),
    .nic_d_out (nic_d_out),
    .nic_en    (nic_en),
    .nic_en_wr (nic_en_wr)
`ifdef NIC_SCHED_STATS_EN
    ,
    .tx_count  (tx_count),
    .rx_count  (rx_count)
`endif
  );

  always #5 clk = ~clk;

  // NIC model state
  int           in_pushed = 0;
  int           in_reads = 0;
  logic [W-1:0] in_buf;
  logic         out_busy;
  logic         in_status;

  assign in_status = (in_pushed > in_reads);

  always_comb begin
    nic_d_out = '0;
    case (nic_addr)
      2'b00: nic_d_out = in_buf;
      2'b01: nic_d_out = {{(W-1){1'b0}}, in_status};
      2'b11: nic_d_out = {{(W-1){1'b0}}, out_busy};
      default: nic_d_out = '0;
    endcase
  end

  // monitor logs what the NIC sees at the coming edge
  logic [W-1:0] wr_log [$];
  logic [N-1:0] rdy_log [$];
  int           trace [$];
  int           n_poll_in = 0;
  int           n_poll_out = 0;
  int           stray = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (nic_en) begin
        case (nic_addr)
          2'b01: begin n_poll_in++; trace.push_back(0); end
          2'b11: begin n_poll_out++; trace.push_back(1); end
          2'b00: in_reads++;
          default: if (nic_en_wr) begin
            wr_log.push_back(nic_d_in);
            rdy_log.push_back(req_ready);
          end
        endcase
      end
      if (!(nic_en && nic_en_wr) && req_ready != '0) stray++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n;
    n = 0;
    while (wr_log.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (wr_log.size() < target)
      chk("write_timeout", 64'(wr_log.size()), 64'(target));
  endtask

  task automatic wait_rx(input int budget);
    int n;
    n = 0;
    while (!rx_valid && n < budget) begin
      tick();
      n++;
    end
    if (!rx_valid) chk("rx_timeout", 64'(rx_valid), 64'd1);
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m,
                                 input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  typedef struct {
    logic [N-1:0] mask;
    int           k;
  } vec_t;

  vec_t         tbl [4];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] expr_q [$];
  int           mptr;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p, w, tb0, tend, bad, n;
    logic [W-1:0] e;
    logic [N-1:0] er;

    tbl[0] = '{4'b1011, 6};
    tbl[1] = '{4'b0100, 2};
    tbl[2] = '{4'b1111, 4};
    tbl[3] = '{4'b1001, 3};

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rx_ready  = 1'b0;
    in_buf    = '0;
    out_busy  = 1'b0;
    mptr      = 0;

    // reset state
    #3;
    chk("rst_en", 64'({nic_en, nic_en_wr, nic_addr}), 64'd0);
    chk("rst_d_in", nic_d_in, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_data", rx_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // idle: only input polls, no writes
    repeat (20) tick();
    chk("idle_no_write", 64'(wr_log.size()), 64'd0);
    chk("idle_polls_in", 64'(n_poll_in > 3), 64'd1);
    chk("idle_no_poll_out", 64'(n_poll_out), 64'd0);

    // rx with backpressure
    in_buf = 64'hDEAD_BEEF_0000_0001;
    in_pushed = in_reads + 1;
    wait_rx(30);
    chk("rx_data", rx_data, 64'hDEAD_BEEF_0000_0001);
    p = n_poll_in;
    repeat (10) tick();
    chk("rx_block_poll", 64'(n_poll_in), 64'(p));
    chk("rx_held", 64'(rx_valid), 64'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_cleared", 64'(rx_valid), 64'd0);
    chk("rx_data_hold", rx_data, 64'hDEAD_BEEF_0000_0001);
    repeat (6) tick();
    chk("rx_poll_resume", 64'(n_poll_in > p), 64'd1);

    // table-driven round-robin tx
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++)
        set_data(i, (64'(t) << 8) | 64'(i + 1));
      base = wr_log.size();
      for (int j = 0; j < tbl[t].k; j++) begin
        w = rr_pick(tbl[t].mask, mptr);
        exp_q.push_back((64'(t) << 8) | 64'(w + 1));
        expr_q.push_back(N'(1) << w);
        mptr = (w + 1) % N;
      end
      req_valid = tbl[t].mask;
      wait_writes(base + tbl[t].k, 200);
      req_valid = '0;
      for (int j = 0; j < tbl[t].k; j++) begin
        e  = exp_q.pop_front();
        er = expr_q.pop_front();
        chk("tx_data", wr_log[base + j], e);
        chk("tx_ready", 64'(rdy_log[base + j]), 64'(er));
      end
      repeat (4) tick();
      chk("tx_no_extra", 64'(wr_log.size()), 64'(base + tbl[t].k));
    end

    // output buffer busy: retry without writing
    out_busy = 1'b1;
    set_data(2, 64'h4444);
    req_valid = 4'b0100;
    base = wr_log.size();
    p = n_poll_out;
    repeat (12) tick();
    chk("busy_no_write", 64'(wr_log.size()), 64'(base));
    chk("busy_repolls", 64'(n_poll_out - p >= 3), 64'd1);
    exp_q.push_back(64'h4444);
    expr_q.push_back(4'b0100);
    out_busy = 1'b0;
    wait_writes(base + 1, 50);
    req_valid = '0;
    e  = exp_q.pop_front();
    er = expr_q.pop_front();
    chk("busy_data", wr_log[base], e);
    chk("busy_ready", 64'(rdy_log[base]), 64'(er));
    repeat (6) tick();
    chk("busy_one_write", 64'(wr_log.size()), 64'(base + 1));
    mptr = 3;

    // rx and tx both eligible: polls alternate
    in_buf = 64'h5555_0000;
    in_pushed = in_reads + 1000;
    rx_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 64'h500 + 64'(i + 1));
    base = wr_log.size();
    tb0 = trace.size();
    req_valid = 4'b1111;
    repeat (40) tick();
    tend = trace.size();
    req_valid = '0;
    in_pushed = in_reads;
    repeat (6) tick();
    in_pushed = in_reads;
    rx_ready = 1'b0;
    bad = 0;
    for (int j = tb0 + 1; j < tend; j++)
      if (trace[j] == trace[j-1]) bad++;
    chk("alt_violations", 64'(bad), 64'd0);
    chk("alt_enough", 64'(tend - tb0 >= 8), 64'd1);
    chk("alt_rx_data", rx_data, 64'h5555_0000);
    n = wr_log.size() - base;
    chk("alt_writes", 64'(n >= 3), 64'd1);
    for (int j = 0; j < n; j++) begin
      w = rr_pick(4'b1111, mptr);
      exp_q.push_back(64'h500 + 64'(w + 1));
      mptr = (w + 1) % N;
      chk("alt_data", wr_log[base + j], exp_q.pop_front());
    end

    // reset in the middle of a write
    in_buf = 64'h66;
    in_pushed = in_reads + 1;
    wait_rx(30);
`ifdef NIC_SCHED_STATS_EN
    chk("stat_tx", 64'(tx_count), 64'(wr_log.size()));
    chk("stat_rx", 64'(rx_count), 64'(in_reads));
`endif
    set_data(0, 64'h6601);
    req_valid = 4'b0001;
    base = wr_log.size();
    n = 0;
    while (!nic_en_wr && n < 30) begin
      tick();
      n++;
    end
    chk("rst_reach_write", 64'(nic_en_wr), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_en", 64'({nic_en, nic_en_wr}), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    chk("rst_mid_rx", 64'(rx_valid), 64'd0);
`ifdef NIC_SCHED_STATS_EN
    chk("rst_tx_count", 64'(tx_count), 64'd0);
    chk("rst_rx_count", 64'(rx_count), 64'd0);
`endif
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("rst_no_write", 64'(wr_log.size()), 64'(base));
    reset = 1'b0;
    repeat (4) tick();
    chk("stray_ready", 64'(stray), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
